// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer
// and branch/jump redirect handling against a single-outstanding-request memory.
module fetch_stage #(
    parameter int                   DATA_SIZE         = 32,
    parameter int                   INSTRUCTION_WIDTH = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC          = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [DATA_SIZE-1:0]         imem_addr,
    input  logic                         imem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    input  logic                         id_stall,
    input  logic                         redirect_valid,
    input  logic [DATA_SIZE-1:0]         redirect_base,
    input  logic [DATA_SIZE-1:0]         redirect_offset,
    output logic                         if_id_valid,
    output logic [INSTRUCTION_WIDTH-1:0] if_id_instruction,
    output logic [DATA_SIZE-1:0]         if_id_pc,
    output logic [DATA_SIZE-1:0]         if_id_pc_plus4
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [DATA_SIZE-1:0] PC_STEP = DATA_SIZE'(4);

    state_t                         state;
    logic [DATA_SIZE-1:0]           pc;
    logic [DATA_SIZE-1:0]           pend_pc;
    logic [DATA_SIZE-1:0]           skid_pc;
    logic [INSTRUCTION_WIDTH-1:0]   skid_instr;
    logic                           req_q;

    logic [DATA_SIZE-1:0]           target;
    logic                           slot_open;

    assign target    = redirect_base + (redirect_offset << 2);
    assign slot_open = !(id_stall && if_id_valid);

    // The request is gated by reset so it reads 0 during the reset cycle itself.
    assign imem_req  = req_q && !reset;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            pend_pc           <= '0;
            skid_pc           <= '0;
            skid_instr        <= '0;
            req_q             <= 1'b1;
            if_id_valid       <= 1'b0;
            if_id_instruction <= '0;
            if_id_pc          <= '0;
            if_id_pc_plus4    <= '0;
        end else begin
            // Slot empties unless held by a stall; loads below override this.
            if (redirect_valid || slot_open) begin
                if_id_valid <= 1'b0;
            end

            case (state)
                FETCH: begin
                    req_q <= 1'b1;
                    if (imem_ready) begin
                        if (redirect_valid) begin
                            pc <= target;
                        end else if (slot_open) begin
                            if_id_valid       <= 1'b1;
                            if_id_instruction <= imem_rdata;
                            if_id_pc          <= pc;
                            if_id_pc_plus4    <= pc + PC_STEP;
                            pc                <= pc + PC_STEP;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            pc         <= pc + PC_STEP;
                            req_q      <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        pend_pc <= target;
                        state   <= DROP;
                    end
                end

                DROP: begin
                    req_q <= 1'b1;
                    if (imem_ready) begin
                        pc    <= redirect_valid ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        pend_pc <= target;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        req_q <= 1'b1;
                        state <= FETCH;
                    end else if (slot_open) begin
                        if_id_valid       <= 1'b1;
                        if_id_instruction <= skid_instr;
                        if_id_pc          <= skid_pc;
                        if_id_pc_plus4    <= skid_pc + PC_STEP;
                        req_q             <= 1'b1;
                        state             <= FETCH;
                    end
                end

                default: begin
                    if_id_valid <= 1'b0;
                    req_q       <= 1'b1;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected memory
// addresses and decoded slots; negedge monitors pop and compare them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [31:0] redirect_offset = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } slot_t;

    slot_t       exp_slots[$];
    logic [31:0] exp_addrs[$];
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_stage #(
        .DATA_SIZE(32),
        .INSTRUCTION_WIDTH(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .id_stall(id_stall),
        .redirect_valid(redirect_valid),
        .redirect_base(redirect_base),
        .redirect_offset(redirect_offset),
        .if_id_valid(if_id_valid),
        .if_id_instruction(if_id_instruction),
        .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4)
    );

    always #5 clk = ~clk;

    // Memory contents: upper half a tag, lower half the address bits.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_base = '0;
        redirect_offset = '0;
        step();
        step();
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instruction, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ready) begin
                if (exp_addrs.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL addr_unexpected: got %h expected none", imem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addrs.pop_front();
                    chk("imem_addr", imem_addr, ea);
                end
            end
            if (if_id_valid && !id_stall && !redirect_valid) begin
                if (exp_slots.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL slot_unexpected: got pc %h expected none", if_id_pc);
                end else begin
                    slot_t es;
                    es = exp_slots.pop_front();
                    chk("slot_instr", if_id_instruction, es.instr);
                    chk("slot_pc", if_id_pc, es.pc);
                    chk("slot_pc4", if_id_pc_plus4, es.pc4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait streaming
        do_reset();
        exp_addrs.push_back(32'h0); exp_addrs.push_back(32'h4);
        exp_addrs.push_back(32'h8); exp_addrs.push_back(32'hC);
        exp_slots.push_back('{32'hC0DE_0000, 32'h0, 32'h4});
        exp_slots.push_back('{32'hC0DE_0004, 32'h4, 32'h8});
        exp_slots.push_back('{32'hC0DE_0008, 32'h8, 32'hC});
        reset = 1'b0; imem_ready = 1'b1;
        #1;
        chk("t1_req_first", {31'd0, imem_req}, 32'd1);
        chk("t1_valid_c0", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("t1_valid_c1", {31'd0, if_id_valid}, 32'd1);
        step(); step(); step();
        imem_ready = 1'b0; id_stall = 1'b1;

        // Three wait states
        do_reset();
        exp_addrs.push_back(32'h0);
        exp_slots.push_back('{32'hC0DE_0000, 32'h0, 32'h4});
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req_wait", {31'd0, imem_req}, 32'd1);
            chk("t2_addr_wait", imem_addr, 32'h0);
            step();
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("t2_valid", {31'd0, if_id_valid}, 32'd1);
        chk("t2_next_addr", imem_addr, 32'h4);
        step();
        id_stall = 1'b1;

        // Stall with memory ready: skid buffer and HOLD
        do_reset();
        exp_addrs.push_back(32'h0); exp_addrs.push_back(32'h4);
        exp_addrs.push_back(32'h8); exp_addrs.push_back(32'hC);
        exp_slots.push_back('{32'hC0DE_0000, 32'h0, 32'h4});
        exp_slots.push_back('{32'hC0DE_0004, 32'h4, 32'h8});
        exp_slots.push_back('{32'hC0DE_0008, 32'h8, 32'hC});
        reset = 1'b0; imem_ready = 1'b1;
        step(); step();
        id_stall = 1'b1;
        step();
        chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t3_hold_pc", if_id_pc, 32'h4);
        chk("t3_hold_valid", {31'd0, if_id_valid}, 32'd1);
        step();
        chk("t3_hold_req2", {31'd0, imem_req}, 32'd0);
        chk("t3_hold_pc2", if_id_pc, 32'h4);
        id_stall = 1'b0;
        step();
        chk("t3_unbuf_pc", if_id_pc, 32'h8);
        chk("t3_resume_req", {31'd0, imem_req}, 32'd1);
        chk("t3_resume_addr", imem_addr, 32'hC);
        step();
        imem_ready = 1'b0; id_stall = 1'b1;

        // Redirect in FETCH with negative offset
        do_reset();
        exp_addrs.push_back(32'h0); exp_addrs.push_back(32'h4); exp_addrs.push_back(32'h38);
        exp_slots.push_back('{32'hC0DE_0038, 32'h38, 32'h3C});
        reset = 1'b0; imem_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_base = 32'h40; redirect_offset = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("t4_flush", {31'd0, if_id_valid}, 32'd0);
        chk("t4_target", imem_addr, 32'h38);
        step();
        imem_ready = 1'b0;
        chk("t4_target_pc", if_id_pc, 32'h38);
        step();
        id_stall = 1'b1;

        // Two redirects while a request waits
        do_reset();
        exp_addrs.push_back(32'h0);
        reset = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_base = 32'hF0; redirect_offset = 32'h4;
        step();
        redirect_base = 32'h100; redirect_offset = 32'h40;
        chk("t5_addr_held1", imem_addr, 32'h0);
        step();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        chk("t5_addr_held2", imem_addr, 32'h0);
        chk("t5_req_held", {31'd0, imem_req}, 32'd1);
        step();
        imem_ready = 1'b0;
        chk("t5_no_load", {31'd0, if_id_valid}, 32'd0);
        chk("t5_latest_target", imem_addr, 32'h200);
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        step();
        id_stall = 1'b1;

        // Reset while in HOLD with stall high
        do_reset();
        exp_addrs.push_back(32'h0); exp_addrs.push_back(32'h4);
        reset = 1'b0; imem_ready = 1'b1;
        step();
        id_stall = 1'b1;
        step();
        chk("t6_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t6_hold_pc", if_id_pc, 32'h0);
        reset = 1'b1;
        step();
        chk("t6_valid", {31'd0, if_id_valid}, 32'd0);
        chk("t6_instr", if_id_instruction, 32'd0);
        chk("t6_pc", if_id_pc, 32'd0);
        chk("t6_pc4", if_id_pc_plus4, 32'd0);
        reset = 1'b0; imem_ready = 1'b0;
        #1;
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, 32'h0);

        // PC wrap at the top of the address space
        do_reset();
        exp_addrs.push_back(32'h0); exp_addrs.push_back(32'hFFFF_FFFC);
        exp_slots.push_back('{32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0});
        reset = 1'b0; imem_ready = 1'b1;
        redirect_valid = 1'b1; redirect_base = 32'hFFFF_FFF0; redirect_offset = 32'h3;
        step();
        redirect_valid = 1'b0;
        chk("t7_top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_ready = 1'b0;
        chk("t7_wrap_addr", imem_addr, 32'h0);
        step();
        id_stall = 1'b1;
        step();

        chk("addr_queue_drained", exp_addrs.size(), 32'd0);
        chk("slot_queue_drained", exp_slots.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of the decode stage.
- Decode hosts the immediate sign extender, which takes if_id_instruction.
- Owns the PC and drives a single-outstanding-request instruction memory port.
- Buffers one returned instruction when decode stalls.
- Redirects the PC on taken BEQ/JUMP, using the sign-extended offset produced downstream.

Parameters:
DATA_SIZE, 32, width of PC, addresses and offsets
INSTRUCTION_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction memory request
imem_addr  output  DATA_SIZE  byte address of request (PC)
imem_ready  input  1  request accepted; imem_rdata valid in same cycle
imem_rdata  input  INSTRUCTION_WIDTH  fetched instruction
id_stall  input  1  decode cannot accept; IF/ID holds
redirect_valid  input  1  taken branch/jump resolved this cycle
redirect_base  input  DATA_SIZE  PC of the branch/jump instruction
redirect_offset  input  DATA_SIZE  sign-extended word offset from sign extender
if_id_valid  output  1  IF/ID holds a live instruction
if_id_instruction  output  INSTRUCTION_WIDTH  instruction to decode
if_id_pc  output  DATA_SIZE  address of if_id_instruction
if_id_pc_plus4  output  DATA_SIZE  if_id_pc + 4

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, state=FETCH, if_id_valid=0.
  - if_id_instruction=0, if_id_pc=0, if_id_pc_plus4=0, skid buffer empty.
  - imem_req is 0 during the reset cycle and 1 in the first cycle after reset.
  - Reset mid-request abandons that request; memory tolerates this.
- Redirect target = redirect_base + (redirect_offset << 2), modulo 2^DATA_SIZE. Negative offsets wrap naturally.
- Memory rules:
  - imem_addr and imem_req are held stable from assertion until the imem_ready cycle.
  - Zero-wait-state responses (ready in the first req cycle) are supported.
  - At most one request is outstanding.
- IF/ID slot update (every cycle):
  - redirect_valid=1: slot flushed, if_id_valid<=0. Redirect beats stall.
  - else id_stall=1 and if_id_valid=1: slot holds all fields.
  - else: slot loads the new instruction if one is delivered this cycle (from memory or buffer); otherwise if_id_valid<=0.
- FETCH state: imem_req=1, imem_addr=pc.
  - ready & redirect_valid: data discarded; pc<=target; stay FETCH.
  - ready & slot can accept: IF/ID<={1, rdata, pc, pc+4}; pc<=pc+4; stay FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  - ready & stalled: rdata and pc go to the skid buffer; pc<=pc+4; go HOLD.
  - !ready & redirect_valid: latch target into pend_pc; go DROP. Request stays at the old address.
- DROP state: imem_req=1, old address held.
  - A further redirect overwrites pend_pc (latest wins).
  - On ready: discard data; pc<=pend_pc, or the new target if a redirect arrives in the same cycle; go FETCH.
- HOLD state: imem_req=0.
  - redirect_valid: buffer discarded; pc<=target; go FETCH.
  - else id_stall=0 or if_id_valid=0: IF/ID<=buffer; go FETCH.
  - else: stay HOLD.
- pc wraps 32'hFFFF_FFFC -> 0. Alignment is not checked; the low 2 bits pass through unchanged.
- An illegal/unused state encoding returns to FETCH with if_id_valid=0.

Test Plan:
1. Zero-wait memory, imem_ready=1 constant, reset released, 4 cycles:
   - imem_addr sequence 0,4,8,12.
   - if_id_pc sequence 0,4,8 one cycle behind.
   - if_id_pc_plus4 = if_id_pc+4; if_id_valid=1 from cycle 2.
2. 3-wait-state memory:
   - imem_addr=0 is held for 3 cycles with imem_req=1.
   - On ready, IF/ID = {1, rdata, 0, 4} the next edge, then addr=4.
3. Stall while ready, with if_id_pc=4 valid and id_stall=1:
   - The instruction at 8 goes to the buffer, state HOLD, imem_req=0; IF/ID keeps pc 4.
   - Drop id_stall: IF/ID gets pc 8, then addr=12 is requested.
4. Redirect in FETCH with zero wait, redirect_base=0x40, redirect_offset=32'hFFFF_FFFE:
   - if_id_valid=0 next cycle.
   - Next imem_addr=0x38.
5. Redirect while waiting:
   - Redirect at wait cycle 1 to target 0x100, then a second redirect to 0x200 before ready.
   - The old address is held; returned data is not loaded; the next request is 0x200.
6. Reset asserted in HOLD with stall high:
   - Next cycle if_id_valid=0 and all IF/ID fields 0.
   - The cycle after, imem_req=1 and imem_addr=RESET_PC.
